// File: rtl/dual_port_ram_arb.sv
// True dual-port RAM with per-byte write enables, selectable read latency,
// read-during-write mode and fixed-priority same-address write arbitration.
// A sweep after reset zeroes the array before any port request is honoured.

// Per-port read pipeline: READ_LATENCY stages of valid/data.
// Data is forced to 0 whenever no read was issued, so dout is 0 while
// valid is 0.
module dual_port_ram_arb_rdpipe #(
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid
);
  logic [LATENCY:1]                 vld_pipe;
  logic [LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

  // Shift valid/data down the pipe; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd;
      dat_pipe[1] <= rd ? rdata : '0;
      for (int k = 2; k <= LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign valid = vld_pipe[LATENCY];
  assign dout  = dat_pipe[LATENCY];
endmodule

module dual_port_ram_arb #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter int PRIORITY     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             init_done,
  output logic                             collision,
  input  logic                             cs0,
  input  logic                             we0,
  input  logic                             oe0,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be0,
  input  logic [ADDR_WIDTH-1:0]            address0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             valid0,
  input  logic                             cs1,
  input  logic                             we1,
  input  logic                             oe1,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be1,
  input  logic [ADDR_WIDTH-1:0]            address1,
  input  logic [DATA_WIDTH-1:0]            din1,
  output logic [DATA_WIDTH-1:0]            dout1,
  output logic                             valid1
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                                 run;
  logic [1:0]                           cs, we, oe;
  logic [1:0][NUM_BYTES-1:0]            be;
  logic [1:0][ADDR_WIDTH-1:0]           addr;
  logic [1:0][DATA_WIDTH-1:0]           din;
  logic [1:0]                           rd_req, wr_req, wr_apply;
  logic [1:0][DATA_WIDTH-1:0]           old_word, merged, rdata, dout_v;
  logic [1:0]                           vld_v;
  logic                                 col_now;

  // Lane-wise merge of new data into the old word under byte enables.
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] nw,
                                                  input logic [NUM_BYTES-1:0]  ben);
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < NUM_BYTES; i++)
      if (ben[i]) r[i*BYTE_WIDTH +: BYTE_WIDTH] = nw[i*BYTE_WIDTH +: BYTE_WIDTH];
    return r;
  endfunction

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sweep one word per cycle; leave INIT once the last address is written.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == S_INIT) begin
      cnt_nxt = cnt + ADDR_WIDTH'(1);
      if (cnt == '1) state_nxt = S_RUN;
    end
  end

  assign run       = (state == S_RUN);
  assign init_done = run;

  assign cs   = {cs1, cs0};
  assign we   = {we1, we0};
  assign oe   = {oe1, oe0};
  assign be   = {be1, be0};
  assign addr = {address1, address0};
  assign din  = {din1, din0};

  // A collision only exists between two real writes; reads never count.
  assign col_now = wr_req[0] & wr_req[1] & (addr[0] == addr[1]);

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign rd_req[p]   = run & cs[p] & oe[p];
    assign wr_req[p]   = run & cs[p] & we[p];
    // The losing port drops its whole write, even on disjoint lanes.
    assign wr_apply[p] = wr_req[p] & ~(col_now & (PRIORITY != p));
    assign old_word[p] = mem[addr[p]];
    assign merged[p]   = merge(old_word[p], din[p], be[p]);
    // Write-first only looks at this port's own write; the other port's
    // write to the same address is never visible in the same cycle.
    assign rdata[p]    = (RDW_MODE == 1 && wr_req[p]) ? merged[p] : old_word[p];

    dual_port_ram_arb_rdpipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LATENCY    (READ_LATENCY)
    ) u_rdpipe (
      .clk   (clk),
      .rst   (rst),
      .rd    (rd_req[p]),
      .rdata (rdata[p]),
      .dout  (dout_v[p]),
      .valid (vld_v[p])
    );
  end

  // Array write: zero sweep during INIT, arbitrated port writes in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) mem[cnt] <= '0;
      else
        for (int p = 0; p < 2; p++)
          if (wr_apply[p]) mem[addr[p]] <= merged[p];
    end
  end

  // Collision flag: one-cycle pulse one edge after the colliding request.
  always_ff @(posedge clk) begin
    if (rst) collision <= 1'b0;
    else     collision <= col_now;
  end

  assign dout0  = dout_v[0];
  assign valid0 = vld_v[0];
  assign dout1  = dout_v[1];
  assign valid1 = vld_v[1];
endmodule

// File: tb/tb_dual_port_ram_arb.sv
// Bench for dual_port_ram_arb: two instances (A: latency 1, read-first,
// port 0 priority; B: latency 2, write-first, port 1 priority) driven by the
// same stimulus and compared every cycle against a behavioural model, plus a
// directed vector table and hand-written reset/init sequences.
module tb_dual_port_ram_arb;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs0, we0, oe0, cs1, we1, oe1;
  logic [1:0]  be0, be1;
  logic [7:0]  a0, a1;
  logic [15:0] d0, d1;

  logic        idn_a, col_a, v0_a, v1_a, idn_b, col_b, v0_b, v1_b;
  logic [15:0] q0_a, q1_a, q0_b, q1_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_port_ram_arb #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BYTE_WIDTH(8),
                      .READ_LATENCY(1), .RDW_MODE(0), .PRIORITY(0)) dut_a (
    .clk(clk), .rst(rst), .init_done(idn_a), .collision(col_a),
    .cs0(cs0), .we0(we0), .oe0(oe0), .be0(be0), .address0(a0), .din0(d0),
    .dout0(q0_a), .valid0(v0_a),
    .cs1(cs1), .we1(we1), .oe1(oe1), .be1(be1), .address1(a1), .din1(d1),
    .dout1(q1_a), .valid1(v1_a));

  dual_port_ram_arb #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BYTE_WIDTH(8),
                      .READ_LATENCY(2), .RDW_MODE(1), .PRIORITY(1)) dut_b (
    .clk(clk), .rst(rst), .init_done(idn_b), .collision(col_b),
    .cs0(cs0), .we0(we0), .oe0(oe0), .be0(be0), .address0(a0), .din0(d0),
    .dout0(q0_b), .valid0(v0_b),
    .cs1(cs1), .we1(we1), .oe1(oe1), .be1(be1), .address1(a1), .din1(d1),
    .dout1(q1_b), .valid1(v1_b));

  // ---------------- reference model ----------------
  int          lat  [2] = '{1, 2};
  int          rdw  [2] = '{0, 1};
  int          prio [2] = '{0, 1};
  int          init_left;
  logic [15:0] mm [2][DEPTH];
  logic        mv [2][2];
  logic [15:0] md [2][2];
  logic        sv [2][2];
  logic [15:0] sd [2][2];
  logic        mcol;

  function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] n,
                                      input logic [1:0] b);
    logic [15:0] r;
    r = o;
    if (b[0]) r[7:0]  = n[7:0];
    if (b[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic        rd [2];
    logic        wr [2];
    logic [1:0]  bb [2];
    logic [7:0]  ad [2];
    logic [15:0] dn [2];
    logic [15:0] r  [2];
    logic        run;
    if (rst) begin
      init_left = DEPTH;
      mcol = 1'b0;
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          mv[i][p] = 1'b0; md[i][p] = 16'h0; sv[i][p] = 1'b0; sd[i][p] = 16'h0;
        end
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < DEPTH; k++) mm[i][k] = 16'h0;
    end else begin
      run = (init_left == 0);
      if (!run) init_left--;
      rd[0] = run && cs0 && oe0;  rd[1] = run && cs1 && oe1;
      wr[0] = run && cs0 && we0;  wr[1] = run && cs1 && we1;
      bb[0] = be0; bb[1] = be1; ad[0] = a0; ad[1] = a1; dn[0] = d0; dn[1] = d1;
      mcol = wr[0] && wr[1] && (ad[0] == ad[1]);
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (!rd[p])                      r[p] = 16'h0;
          else if (rdw[i] == 1 && wr[p])   r[p] = mrg(mm[i][ad[p]], dn[p], bb[p]);
          else                             r[p] = mm[i][ad[p]];
        end
        for (int p = 0; p < 2; p++)
          if (wr[p] && !(mcol && p != prio[i]))
            mm[i][ad[p]] = mrg(mm[i][ad[p]], dn[p], bb[p]);
        for (int p = 0; p < 2; p++) begin
          if (lat[i] == 1) begin
            mv[i][p] = rd[p]; md[i][p] = r[p];
          end else begin
            mv[i][p] = sv[i][p]; md[i][p] = sd[i][p];
            sv[i][p] = rd[p];    sd[i][p] = r[p];
          end
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk1(input string nm, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic cmp_all();
    chk1 ("A.init_done", idn_a, init_left == 0);
    chk1 ("A.collision", col_a, mcol);
    chk1 ("A.valid0", v0_a, mv[0][0]);
    chk16("A.dout0",  q0_a, md[0][0]);
    chk1 ("A.valid1", v1_a, mv[0][1]);
    chk16("A.dout1",  q1_a, md[0][1]);
    chk1 ("B.init_done", idn_b, init_left == 0);
    chk1 ("B.collision", col_b, mcol);
    chk1 ("B.valid0", v0_b, mv[1][0]);
    chk16("B.dout0",  q0_b, md[1][0]);
    chk1 ("B.valid1", v1_b, mv[1][1]);
    chk16("B.dout1",  q1_b, md[1][1]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle();
    {cs0, we0, oe0} = 3'b000; be0 = 2'b00; a0 = 8'h00; d0 = 16'h0;
    {cs1, we1, oe1} = 3'b000; be1 = 2'b00; a1 = 8'h00; d1 = 16'h0;
  endtask

  task automatic rand_in(input bit wide);
    cs0 = ($urandom_range(0, 3) != 0);
    we0 = 1'($urandom_range(0, 1));
    oe0 = 1'($urandom_range(0, 1));
    be0 = 2'($urandom_range(0, 3));
    a0  = wide ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
    d0  = 16'($urandom_range(0, 65535));
    cs1 = ($urandom_range(0, 3) != 0);
    we1 = 1'($urandom_range(0, 1));
    oe1 = 1'($urandom_range(0, 1));
    be1 = 2'($urandom_range(0, 3));
    a1  = wide ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
    d1  = 16'($urandom_range(0, 65535));
  endtask

  // ---------------- directed vector table ----------------
  // c = {cs, we, oe}; av/bv = {valid0, valid1} of instance A / B.
  typedef struct {
    logic [2:0]  c0; logic [1:0] be0; logic [7:0] a0; logic [15:0] d0;
    logic [2:0]  c1; logic [1:0] be1; logic [7:0] a1; logic [15:0] d1;
    logic        col;
    logic [1:0]  av; logic [15:0] ad0; logic [15:0] ad1;
    logic [1:0]  bv; logic [15:0] bd0; logic [15:0] bd1;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  initial begin
    vt[0]  = '{3'b110,2'b11,8'h10,16'h00A5, 3'b000,2'b00,8'h00,16'h0000, 1'b0,
               2'b00,16'h0000,16'h0000, 2'b00,16'h0000,16'h0000};
    vt[1]  = '{3'b000,2'b00,8'h00,16'h0000, 3'b101,2'b00,8'h10,16'h0000, 1'b0,
               2'b01,16'h0000,16'h00A5, 2'b01,16'h0000,16'h00A5};
    vt[2]  = '{3'b110,2'b11,8'h03,16'h1234, 3'b000,2'b00,8'h00,16'h0000, 1'b0,
               2'b00,16'h0000,16'h0000, 2'b00,16'h0000,16'h0000};
    vt[3]  = '{3'b110,2'b01,8'h03,16'hABCD, 3'b000,2'b00,8'h00,16'h0000, 1'b0,
               2'b00,16'h0000,16'h0000, 2'b00,16'h0000,16'h0000};
    vt[4]  = '{3'b000,2'b00,8'h00,16'h0000, 3'b101,2'b00,8'h03,16'h0000, 1'b0,
               2'b01,16'h0000,16'h12CD, 2'b01,16'h0000,16'h12CD};
    vt[5]  = '{3'b110,2'b11,8'h20,16'h0011, 3'b110,2'b11,8'h20,16'h0022, 1'b1,
               2'b00,16'h0000,16'h0000, 2'b00,16'h0000,16'h0000};
    vt[6]  = '{3'b101,2'b00,8'h20,16'h0000, 3'b101,2'b00,8'h21,16'h0000, 1'b0,
               2'b11,16'h0011,16'h0000, 2'b11,16'h0022,16'h0000};
    vt[7]  = '{3'b110,2'b11,8'h20,16'h0033, 3'b110,2'b11,8'h21,16'h0044, 1'b0,
               2'b00,16'h0000,16'h0000, 2'b00,16'h0000,16'h0000};
    vt[8]  = '{3'b101,2'b00,8'h20,16'h0000, 3'b101,2'b00,8'h21,16'h0000, 1'b0,
               2'b11,16'h0033,16'h0044, 2'b11,16'h0033,16'h0044};
    vt[9]  = '{3'b110,2'b11,8'h05,16'h000F, 3'b000,2'b00,8'h00,16'h0000, 1'b0,
               2'b00,16'h0000,16'h0000, 2'b00,16'h0000,16'h0000};
    vt[10] = '{3'b111,2'b11,8'h05,16'h00F0, 3'b101,2'b00,8'h05,16'h0000, 1'b0,
               2'b11,16'h000F,16'h000F, 2'b11,16'h00F0,16'h000F};
    vt[11] = '{3'b101,2'b00,8'h05,16'h0000, 3'b111,2'b10,8'h05,16'hBB00, 1'b0,
               2'b11,16'h00F0,16'h00F0, 2'b11,16'h00F0,16'hBBF0};
    vt[12] = '{3'b110,2'b01,8'h30,16'h0077, 3'b110,2'b10,8'h30,16'h8800, 1'b1,
               2'b00,16'h0000,16'h0000, 2'b00,16'h0000,16'h0000};
    vt[13] = '{3'b101,2'b00,8'h30,16'h0000, 3'b101,2'b00,8'h05,16'h0000, 1'b0,
               2'b11,16'h0077,16'hBBF0, 2'b11,16'h8800,16'hBBF0};
    vt[14] = '{3'b000,2'b00,8'h00,16'h0000, 3'b000,2'b00,8'h00,16'h0000, 1'b0,
               2'b00,16'h0000,16'h0000, 2'b00,16'h0000,16'h0000};

    // Reset and init sweep.
    idle();
    rst = 1'b1;
    cycle();
    chk1("rst.A.init_done", idn_a, 1'b0);
    chk1("rst.B.valid0", v0_b, 1'b0);
    cycle();
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      cycle();
      if (k == DEPTH - 1) chk1("t1.A.busy_last", idn_a, 1'b0);
      if (k == DEPTH)     chk1("t1.A.done", idn_a, 1'b1);
    end

    // Reads of the freshly swept array.
    {cs0, we0, oe0} = 3'b101; a0 = 8'h00;
    {cs1, we1, oe1} = 3'b101; a1 = 8'h7F;
    cycle();
    chk1 ("t1.A.v0", v0_a, 1'b1);
    chk16("t1.A.rd00", q0_a, 16'h0);
    chk16("t1.A.rd7f", q1_a, 16'h0);
    a0 = 8'hFF; {cs1, we1, oe1} = 3'b000;
    cycle();
    chk16("t1.A.rdff", q0_a, 16'h0);
    chk1 ("t1.B.v0", v0_b, 1'b1);
    chk1 ("t1.B.v1", v1_b, 1'b1);
    idle();
    cycle();
    chk1 ("t1.B.vff", v0_b, 1'b1);
    chk16("t1.B.rdff", q0_b, 16'h0);

    // Directed table; B's reads land one edge after A's.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        {cs0, we0, oe0} = vt[i].c0; be0 = vt[i].be0; a0 = vt[i].a0; d0 = vt[i].d0;
        {cs1, we1, oe1} = vt[i].c1; be1 = vt[i].be1; a1 = vt[i].a1; d1 = vt[i].d1;
      end else idle();
      cycle();
      if (i < NV) begin
        chk1 ($sformatf("tbl%0d.A.col", i), col_a, vt[i].col);
        chk1 ($sformatf("tbl%0d.B.col", i), col_b, vt[i].col);
        chk1 ($sformatf("tbl%0d.A.v0", i), v0_a, vt[i].av[1]);
        chk16($sformatf("tbl%0d.A.d0", i), q0_a, vt[i].ad0);
        chk1 ($sformatf("tbl%0d.A.v1", i), v1_a, vt[i].av[0]);
        chk16($sformatf("tbl%0d.A.d1", i), q1_a, vt[i].ad1);
      end
      if (i > 0) begin
        chk1 ($sformatf("tbl%0d.B.v0", i-1), v0_b, vt[i-1].bv[1]);
        chk16($sformatf("tbl%0d.B.d0", i-1), q0_b, vt[i-1].bd0);
        chk1 ($sformatf("tbl%0d.B.v1", i-1), v1_b, vt[i-1].bv[0]);
        chk16($sformatf("tbl%0d.B.d1", i-1), q1_b, vt[i-1].bd1);
      end
    end

    // Random traffic, mostly on a small address window to force collisions.
    for (int k = 0; k < 1500; k++) begin
      rand_in(k % 4 == 0);
      cycle();
    end

    // Reset in the middle of a read stream.
    idle();
    {cs0, we0, oe0} = 3'b101; a0 = 8'h03;
    {cs1, we1, oe1} = 3'b101; a1 = 8'h05;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk1("t6.B.v0", v0_b, 1'b0);
    chk1("t6.B.v1", v1_b, 1'b0);
    chk1("t6.A.v0", v0_a, 1'b0);
    chk1("t6.A.init_done", idn_a, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      rand_in(1'b0);
      {cs0, we0, oe0} = 3'b111; be0 = 2'b11;
      cycle();
      if (k < DEPTH - 1) begin
        chk1("t6.init.A.v0", v0_a, 1'b0);
        chk1("t6.init.B.v0", v0_b, 1'b0);
      end
    end
    chk1("t6.A.done", idn_a, 1'b1);
    chk1("t6.B.done", idn_b, 1'b1);
    idle();
    {cs0, we0, oe0} = 3'b101; a0 = 8'h03;
    {cs1, we1, oe1} = 3'b101; a1 = 8'h05;
    cycle();
    chk1 ("t6.A.v0", v0_a, 1'b1);
    chk16("t6.A.rd3", q0_a, 16'h0);
    chk16("t6.A.rd5", q1_a, 16'h0);
    idle();
    cycle();
    chk1 ("t6.B.v0", v0_b, 1'b1);
    chk16("t6.B.rd3", q0_b, 16'h0);
    chk16("t6.B.rd5", q1_b, 16'h0);

    // More random traffic after the restart.
    for (int k = 0; k < 600; k++) begin
      rand_in(k % 3 == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
